myfilter_dp: RTL
================

// Module: myfilter_dp
// PURPOSE
//  5-tap FIR datapath; consumer end of the dp_cmd_t command stream (myfilter_pkg).
//  Executes one command per clock: delay-line shift, MAC per tap, saturate/output.
//  Sits beside the filter controller; holds the coefficient file, written by the host port.
// PARAMETERS
//  DATA_W   16  signed sample width (in and out)
//  COEFF_W  16  signed coefficient width, Q1.(COEFF_W-1)
//  ACC_W    35  accumulator width = DATA_W+COEFF_W+3 guard bits (5 taps)
// PORTS
//  clk            in   1        clock; all state updates on posedge
//  rst            in   1        synchronous, active-high reset
//  cmd_in         in   dp_cmd_t command for this cycle
//  ext_data_in    in   DATA_W   signed sample, sampled on CMD_SHIFT
//  coeff_we_in    in   1        coefficient write strobe
//  coeff_addr_in  in   3        coefficient index 0..4
//  coeff_data_in  in   COEFF_W  signed coefficient value
//  ext_data_out   out  DATA_W   last filter result (registered, held)
//  ext_valid_out  out  1        1-cycle pulse: new ext_data_out
//  sat_flag_out   out  1        1 = last result was clipped (held with ext_data_out)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): x[0..4], c[0..4], acc, ext_data_out, sat_flag_out,
//    ext_valid_out all <= 0; rst overrides cmd_in and coeff_we_in.
//  - Command decode (one per cycle, all registered):
//    CMD_NOP    : hold all state; ext_valid_out=0
//    CMD_SHIFT  : x[0]<=ext_data_in; x[k]<=x[k-1], k=1..4
//    CMD_TAP0F  : acc <= sext(x[0]*c[0])            (clear-and-load, starts a frame)
//    CMD_TAP0   : acc <= acc + sext(x[0]*c[0])      (no clear)
//    CMD_TAPk   : acc <= acc + sext(x[k]*c[k]), k=1..4
//    CMD_SAT_SH : y = acc >>> (COEFF_W-1) (arith shift, truncate toward -inf);
//                 ext_data_out <= clip(y) to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
//                 sat_flag_out <= (y out of range); ext_valid_out <= 1 next cycle
//    undefined encodings: treated as CMD_NOP
//  - Products: full-precision signed DATA_W+COEFF_W bits, sign-extended to ACC_W;
//    acc add wraps modulo 2^ACC_W (cannot overflow for 5 taps at given ACC_W).
//  - Latency: CMD_SAT_SH in cycle n -> ext_data_out/sat_flag_out/ext_valid_out
//    updated at posedge ending cycle n (visible cycle n+1); valid high exactly 1 cycle.
//  - Outputs and acc untouched by SHIFT/NOP; ext_data_out holds until next SAT_SH.
//  - Coefficient write: coeff_we_in=1 writes c[coeff_addr_in] at posedge;
//    addr 5..7 ignored (no state change). Write in same cycle as a TAP using that
//    coefficient: TAP uses the old value; new value used from next cycle.
//  - SHIFT and coefficient write in same cycle: both take effect, independent.
//  - Reset mid-frame: acc cleared, no ext_valid_out pulse; next TAP0F restarts cleanly.
// TESTING
//  1 Reset: rst=1 with cmd_in=CMD_SHIFT, ext_data_in=0x1234 -> x[0]=0, outputs all 0.
//  2 Impulse: c={8192,16384,-8192,4096,0}; SHIFT 32767 then frames with SHIFT 0,
//    each frame TAP0F,TAP1..4,SAT_SH -> outputs 8191,16383,-8192,4095,0 (in order
//    of impulse at tap 0..4), sat_flag_out=0, one valid pulse per frame.
//  3 Saturation: all c=32767, x all 32767 -> ext_data_out=32767, sat_flag=1;
//    x all -32768 -> ext_data_out=-32768, sat_flag=1.
//  4 NOP insertion: random NOPs between TAP commands -> identical results to test 2,
//    no extra valid pulses.
//  5 Coeff write c[2]<=100 in same cycle as TAP2 -> that frame uses old c[2], next
//    frame uses 100; write to addr 6 -> no coefficient changes.
//  6 Reset after TAP2 mid-frame -> no valid pulse; following full frame gives correct
//    result for post-reset delay line.

Source files
------------

// File: rtl/myfilter_dp.sv
// 5-tap FIR datapath: executes one dp_cmd_t per clock (shift, MAC, saturate) and
// holds the host-writable coefficient file.

package myfilter_pkg;
    typedef enum logic [3:0] {
        CMD_NOP    = 4'd0,
        CMD_SHIFT  = 4'd1,
        CMD_TAP0F  = 4'd2,
        CMD_TAP0   = 4'd3,
        CMD_TAP1   = 4'd4,
        CMD_TAP2   = 4'd5,
        CMD_TAP3   = 4'd6,
        CMD_TAP4   = 4'd7,
        CMD_SAT_SH = 4'd8
    } dp_cmd_t;
endpackage

module myfilter_dp
    import myfilter_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned ACC_W   = 35
) (
    input  logic               clk,
    input  logic               rst,
    input  dp_cmd_t            cmd_in,
    input  logic [DATA_W-1:0]  ext_data_in,
    input  logic               coeff_we_in,
    input  logic [2:0]         coeff_addr_in,
    input  logic [COEFF_W-1:0] coeff_data_in,
    output logic [DATA_W-1:0]  ext_data_out,
    output logic               ext_valid_out,
    output logic               sat_flag_out
);

    localparam int unsigned PW    = DATA_W + COEFF_W;
    localparam int unsigned NTAPS = 5;

    logic [DATA_W-1:0]  x_q [NTAPS];
    logic [DATA_W-1:0]  x_d [NTAPS];
    logic [COEFF_W-1:0] c_q [NTAPS];
    logic [COEFF_W-1:0] c_d [NTAPS];
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;

    logic               tap_en, tap_clr;
    logic [2:0]         tap_sel;
    logic [DATA_W-1:0]  tap_x;
    logic [COEFF_W-1:0] tap_c;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   y;
    logic               y_oor;

    always_comb begin
        tap_en  = 1'b0;
        tap_clr = 1'b0;
        tap_sel = 3'd0;
        case (cmd_in)
            CMD_TAP0F: begin tap_en = 1'b1; tap_clr = 1'b1; end
            CMD_TAP0:  tap_en = 1'b1;
            CMD_TAP1:  begin tap_en = 1'b1; tap_sel = 3'd1; end
            CMD_TAP2:  begin tap_en = 1'b1; tap_sel = 3'd2; end
            CMD_TAP3:  begin tap_en = 1'b1; tap_sel = 3'd3; end
            CMD_TAP4:  begin tap_en = 1'b1; tap_sel = 3'd4; end
            default:   ;
        endcase
    end

    always_comb begin
        tap_x = x_q[0];
        tap_c = c_q[0];
        for (int k = 1; k < NTAPS; k++) begin
            if (tap_sel == 3'(k)) begin
                tap_x = x_q[k];
                tap_c = c_q[k];
            end
        end
    end

    // Operands sign-extended to full product width so the low PW bits are exact.
    assign prod = $signed({{COEFF_W{tap_x[DATA_W-1]}}, tap_x})
                * $signed({{DATA_W{tap_c[COEFF_W-1]}}, tap_c});
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

    assign y     = $signed(acc_q) >>> (COEFF_W - 1);
    assign y_oor = !((&y[ACC_W-1:DATA_W-1]) || !(|y[ACC_W-1:DATA_W-1]));

    always_comb begin
        x_d     = x_q;
        c_d     = c_q;
        acc_d   = acc_q;
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = 1'b0;

        case (cmd_in)
            CMD_SHIFT: begin
                x_d[0] = ext_data_in;
                for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
            end
            CMD_SAT_SH: begin
                valid_d = 1'b1;
                sat_d   = y_oor;
                if (!y_oor)          data_d = y[DATA_W-1:0];
                else if (y[ACC_W-1]) data_d = {1'b1, {(DATA_W-1){1'b0}}};
                else                 data_d = {1'b0, {(DATA_W-1){1'b1}}};
            end
            default: ;
        endcase

        if (tap_en) acc_d = tap_clr ? prod_ext : acc_q + prod_ext;

        // Addresses 5..7 match no entry and are dropped.
        if (coeff_we_in) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (coeff_addr_in == 3'(k)) c_d[k] = coeff_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            acc_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign ext_data_out  = data_q;
    assign ext_valid_out = valid_q;
    assign sat_flag_out  = sat_q;

endmodule
